// File: rtl/otter_hazard_pkg.sv
// Shared types and constants for the OTTER pipeline hazard controller.
package otter_hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    ERROR   = 2'b10
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // Encoding the pipeline registers load when nulled (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/otter_fwd_unit.sv
// EX-stage operand forwarding select for both ALU operands; purely combinational.
module otter_fwd_unit
  import otter_hazard_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwr,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwr,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b
);

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  function automatic fwd_sel_t pick(input logic [4:0] rs);
    if (mem_regwr && (mem_rd != 5'd0) && (mem_rd == rs))
      return FWD_MEM;
    else if (wb_regwr && (wb_rd != 5'd0) && (wb_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign fwd_a = pick(ex_rs1);
  assign fwd_b = pick(ex_rs2);

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER pipeline hazard controller: load-use stalls, branch flushes, memory-wait
// freeze with watchdog, forwarding selects and performance counters.
module otter_hazard_ctrl
  import otter_hazard_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwr,
  input  logic             ex_isload,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwr,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwr,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_null,
  output logic             idex_en,
  output logic             idex_null,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_nxt;
  logic              err_q;
  logic              load_use, freeze, flush, stall;
  fwd_sel_t          sel_a, sel_b;

  assign load_use = ex_isload && ex_regwr && (ex_rd != 5'd0) &&
                    ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    wait_nxt = '0;
    freeze   = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    case (state_q)
      RUN, MEMWAIT: begin
        if (mem_busy) begin
          freeze   = 1'b1;
          wait_nxt = (state_q == MEMWAIT) ? wait_q + WAIT_W'(1) : WAIT_W'(1);
          if (wait_nxt >= WAIT_W'(TIMEOUT)) begin
            state_d = ERROR;
          end else begin
            state_d = MEMWAIT;
            wait_d  = wait_nxt;
          end
        end else begin
          // Release from MEMWAIT resolves branch/load-use in this same cycle.
          state_d = RUN;
          wait_d  = '0;
          flush   = br_taken;
          stall   = !br_taken && load_use;
        end
      end
      default: freeze = 1'b1;
    endcase
  end

  assign pc_en     = !freeze && !stall;
  assign ifid_en   = !freeze && !stall;
  assign ifid_null = flush;
  assign idex_en   = !freeze;
  assign idex_null = flush || stall;
  assign exmem_en  = !freeze;
  assign memwb_en  = !freeze;
  assign err       = err_q;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      err_q     <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_d == ERROR) err_q <= 1'b1;
      if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  otter_fwd_unit u_fwd (
    .ex_rs1    (ex_rs1),
    .ex_rs2    (ex_rs2),
    .mem_rd    (mem_rd),
    .mem_regwr (mem_regwr),
    .wb_rd     (wb_rd),
    .wb_regwr  (wb_regwr),
    .fwd_a     (sel_a),
    .fwd_b     (sel_b)
  );

  assign fwd_a = sel_a;
  assign fwd_b = sel_b;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Scoreboard bench for otter_hazard_ctrl: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_otter_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic        id_use1, id_use2, ex_regwr, ex_isload, mem_regwr, wb_regwr;
  logic        br_taken, mem_busy;
  logic        pc_en, ifid_en, ifid_null, idex_en, idex_null, exmem_en, memwb_en;
  logic [1:0]  fwd_a, fwd_b;
  logic        err;
  logic [31:0] stall_cnt, flush_cnt;

  // Control bundle order: pc_en ifid_en ifid_null idex_en idex_null exmem_en memwb_en
  localparam logic [6:0] C_RUN   = 7'b1101011;
  localparam logic [6:0] C_FRZ   = 7'b0000000;
  localparam logic [6:0] C_FLUSH = 7'b1111111;
  localparam logic [6:0] C_STALL = 7'b0001111;

  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        err;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  otter_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_isload(ex_isload),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_regwr(mem_regwr), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .br_taken(br_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_null(ifid_null),
    .idex_en(idex_en), .idex_null(idex_null), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .err(err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: outputs are settled at the negedge, half a cycle after inputs change.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, "_ctl"}, 32'({pc_en, ifid_en, ifid_null, idex_en, idex_null,
                                     exmem_en, memwb_en}), 32'(e.ctl));
        check({e.name, "_fwd"}, 32'({fwd_a, fwd_b}), 32'({e.fa, e.fb}));
        check({e.name, "_err"}, 32'(err), 32'(e.err));
        check({e.name, "_stall_cnt"}, stall_cnt, e.stall);
        check({e.name, "_flush_cnt"}, flush_cnt, e.flush);
      end
    end
  end

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
    ex_rd = 0; ex_regwr = 0; ex_isload = 0; ex_rs1 = 0; ex_rs2 = 0;
    mem_rd = 0; mem_regwr = 0; wb_rd = 0; wb_regwr = 0;
    br_taken = 0; mem_busy = 0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    ex_isload = 1; ex_regwr = 1; ex_rd = rd; id_rs1 = rd; id_use1 = 1;
  endtask

  // Inputs are applied 1 time unit after posedge; expectation covers this cycle.
  task automatic step(input string n, input logic [6:0] c, input logic [1:0] a,
                      input logic [1:0] b, input logic e, input int s, input int f);
    exp_t x;
    x.name = n; x.ctl = c; x.fa = a; x.fb = b; x.err = e;
    x.stall = 32'(s); x.flush = 32'(f);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk); #1;
    step("in_reset", C_RUN, 2'b00, 2'b00, 0, 0, 0);
    rst_n = 1'b1;
    step("idle", C_RUN, 2'b00, 2'b00, 0, 0, 0);

    // Load-use stalls and their non-triggering variants
    idle(); load_use(5);
    step("lu_rs1", C_STALL, 2'b00, 2'b00, 0, 0, 0);
    idle(); ex_regwr = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1;
    mem_rd = 5; mem_regwr = 1; ex_rs1 = 5;
    step("lu_release", C_RUN, 2'b01, 2'b00, 0, 1, 0);
    idle(); ex_isload = 1; ex_regwr = 1; ex_rd = 9; id_rs1 = 9; id_rs2 = 9; id_use2 = 1;
    step("lu_rs2", C_STALL, 2'b00, 2'b00, 0, 1, 0);
    idle(); load_use(0);
    step("lu_x0", C_RUN, 2'b00, 2'b00, 0, 2, 0);
    idle(); load_use(3); ex_regwr = 0;
    step("lu_noregwr", C_RUN, 2'b00, 2'b00, 0, 2, 0);
    idle(); load_use(5); br_taken = 1;
    step("br_over_lu", C_FLUSH, 2'b00, 2'b00, 0, 2, 0);
    idle();
    step("after_br", C_RUN, 2'b00, 2'b00, 0, 2, 1);

    // Forwarding priority and x0
    idle(); mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_regwr = 1; wb_regwr = 1;
    step("fwd_mem_pri", C_RUN, 2'b01, 2'b00, 0, 2, 1);
    mem_rd = 8;
    step("fwd_wb", C_RUN, 2'b10, 2'b00, 0, 2, 1);
    ex_rs1 = 0; mem_rd = 0; wb_rd = 0;
    step("fwd_x0", C_RUN, 2'b00, 2'b00, 0, 2, 1);
    idle(); ex_rs1 = 12; ex_rs2 = 12; mem_rd = 12; wb_rd = 12; wb_regwr = 1;
    step("fwd_b_wb", C_RUN, 2'b10, 2'b10, 0, 2, 1);
    mem_regwr = 1;
    step("fwd_b_mem", C_RUN, 2'b01, 2'b01, 0, 2, 1);
    mem_regwr = 0; wb_regwr = 0;
    step("fwd_none", C_RUN, 2'b00, 2'b00, 0, 2, 1);

    // Memory wait: freeze three cycles, branch resolved on the release cycle
    idle(); mem_busy = 1; br_taken = 1; load_use(5);
    for (int i = 0; i < 3; i++) step($sformatf("memwait%0d", i), C_FRZ, 2'b00, 2'b00, 0, 2, 1);
    mem_busy = 0;
    step("mw_release_br", C_FLUSH, 2'b00, 2'b00, 0, 2, 1);
    idle();
    step("mw_after", C_RUN, 2'b00, 2'b00, 0, 2, 2);

    // Watchdog: TIMEOUT=4, busy held six cycles
    idle(); mem_busy = 1;
    for (int i = 0; i < 4; i++) step($sformatf("to_busy%0d", i), C_FRZ, 2'b00, 2'b00, 0, 2, 2);
    for (int i = 4; i < 6; i++) step($sformatf("to_busy%0d", i), C_FRZ, 2'b00, 2'b00, 1, 2, 2);
    idle(); br_taken = 1;
    step("err_hold_br", C_FRZ, 2'b00, 2'b00, 1, 2, 2);
    idle(); load_use(6);
    step("err_hold_lu", C_FRZ, 2'b00, 2'b00, 1, 2, 2);

    // Asynchronous reset between edges clears error and counters
    idle(); rst_n = 1'b0;
    step("async_rst_err", C_RUN, 2'b00, 2'b00, 0, 0, 0);
    rst_n = 1'b1;
    step("post_rst", C_RUN, 2'b00, 2'b00, 0, 0, 0);
    mem_busy = 1;
    step("rst_mw0", C_FRZ, 2'b00, 2'b00, 0, 0, 0);
    step("rst_mw1", C_FRZ, 2'b00, 2'b00, 0, 0, 0);
    idle(); rst_n = 1'b0;
    step("async_rst_mw", C_RUN, 2'b00, 2'b00, 0, 0, 0);
    rst_n = 1'b1; load_use(4);
    step("post_rst_lu", C_STALL, 2'b00, 2'b00, 0, 0, 0);
    idle();
    step("post_rst_idle", C_RUN, 2'b00, 2'b00, 0, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
